instruction_fetch_unit: RTL and testbench

//  Owns the program counter and fetches one 32-bit instruction per step from instruction memory.

---
 rtl/instruction_fetch_unit_if.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
//==============================================================================
// Module   : instruction_fetch_unit_if
// Purpose  : Memory, decode-handshake and redirect bundle of the fetch unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4, fault,
        input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_imm,
               jump, jump_target, jump_reg, reg_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4, fault,
        output imem_ack, imem_rdata, instr_ready, branch_taken, branch_imm,
               jump, jump_target, jump_reg, reg_target
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
//==============================================================================
// Module   : instruction_fetch_unit
// Purpose  : PC owner and multi-cycle instruction fetcher with valid/ready out.
//            Optional macro IFU_FAULT_EN adds misalign/ack-timeout fault state.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  wire logic                clk,
    input  wire logic                reset,
    instruction_fetch_unit_if.master bus
);

`ifdef IFU_FAULT_EN
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int              c_wait_w    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MAX_WAIT - 1);

    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_wait_w-1:0] w_wait_nxt;
`else
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;
`endif

    if (MAX_WAIT < 1) begin : g_max_wait_check
        $error("MAX_WAIT must be at least 1");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic        w_instr_ld;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_target = w_pc_plus4;
        if (bus.jump_reg)
            w_target = bus.reg_target;
        else if (bus.jump)
            w_target = {w_pc_plus4[31:28], bus.jump_target, 2'b00};
        else if (bus.branch_taken)
            w_target = w_pc_plus4 + {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
    end

`ifdef IFU_FAULT_EN
    assign w_next_pc = w_target;
`else
    // Without fault reporting a misaligned register target is silently word-aligned.
    assign w_next_pc = w_target & ~32'd3;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_START;
            r_pc    <= RESET_PC;
            r_instr <= '0;
`ifdef IFU_FAULT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_instr_ld)
                r_instr <= bus.imem_rdata;
`ifdef IFU_FAULT_EN
            r_wait_cnt <= w_wait_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_ld  = 1'b0;
`ifdef IFU_FAULT_EN
        w_wait_nxt  = '0;
`endif
        case (r_state)
            S_START: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    w_instr_ld  = 1'b1;
                    w_state_nxt = S_VALID;
                end
`ifdef IFU_FAULT_EN
                else if (r_wait_cnt == c_wait_last)
                    w_state_nxt = S_FAULT;
                else
                    w_wait_nxt = r_wait_cnt + 1'b1;
`endif
            end
            S_VALID: begin
                if (bus.instr_ready) begin
                    w_pc_nxt    = w_next_pc;
                    w_state_nxt = S_FETCH;
`ifdef IFU_FAULT_EN
                    if (w_next_pc[1:0] != 2'b00)
                        w_state_nxt = S_FAULT;
`endif
                end
            end
`ifdef IFU_FAULT_EN
            S_FAULT: w_state_nxt = S_FAULT;
`endif
            default: w_state_nxt = S_START;
        endcase
    end

    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = (r_state == S_VALID);
    assign bus.instr_out   = r_instr;
    assign bus.pc_out      = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
`ifdef IFU_FAULT_EN
    assign bus.fault       = (r_state == S_FAULT);
`else
    assign bus.fault       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
//==============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Scoreboard bench for instruction_fetch_unit (honours IFU_FAULT_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [31:0] sb_q[$];

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br,
                                               input logic [15:0] imm, input logic jmp,
                                               input logic [25:0] tgt, input logic jr,
                                               input logic [31:0] rt);
        logic [31:0] seq;
        logic [31:0] n;
        seq = pc + 32'd4;
        if (jr)       n = rt;
        else if (jmp) n = {seq[31:28], tgt, 2'b00};
        else if (br)  n = seq + 32'($signed(imm)) * 32'd4;
        else          n = seq;
`ifndef IFU_FAULT_EN
        n[1:0] = 2'b00;
`endif
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'hDEAD_BEEF;
        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_imm   = '0;
        bus.jump         = 1'b0;
        bus.jump_target  = '0;
        bus.jump_reg     = 1'b0;
        bus.reg_target   = '0;
    endtask

    // Entered with the DUT in the fetch state; leaves it in the fetch state of the next PC.
    task automatic fetch_one(input int delay, input int hold, input logic br,
                             input logic [15:0] imm, input logic jmp, input logic [25:0] tgt,
                             input logic jr, input logic [31:0] rt);
        logic [31:0] a;
        logic [31:0] w;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'(sb_q.size()), 32'd1);
            return;
        end
        a = sb_q.pop_front();
        w = mem_word(a);
        check_val("req", 32'(bus.imem_req), 32'd1);
        check_val("addr", bus.imem_addr, a);
        for (int i = 0; i < delay; i++) begin
            step();
            check_val("req_wait", 32'(bus.imem_req), 32'd1);
            check_val("addr_hold", bus.imem_addr, a);
            check_val("valid_wait", 32'(bus.instr_valid), 32'd0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        check_val("valid", 32'(bus.instr_valid), 32'd1);
        check_val("req_off", 32'(bus.imem_req), 32'd0);
        check_val("instr", bus.instr_out, w);
        check_val("pc", bus.pc_out, a);
        check_val("pc4", bus.pc_plus4, a + 32'd4);
        for (int i = 0; i < hold; i++) begin
            bus.jump_reg   = 1'b1;
            bus.reg_target = $urandom;
            step();
            check_val("hold_valid", 32'(bus.instr_valid), 32'd1);
            check_val("hold_instr", bus.instr_out, w);
            check_val("hold_pc", bus.pc_out, a);
            check_val("hold_req", 32'(bus.imem_req), 32'd0);
        end
        bus.instr_ready  = 1'b1;
        bus.branch_taken = br;
        bus.branch_imm   = imm;
        bus.jump         = jmp;
        bus.jump_target  = tgt;
        bus.jump_reg     = jr;
        bus.reg_target   = rt;
        sb_q.push_back(model_next(a, br, imm, jmp, tgt, jr, rt));
        step();
        idle_inputs();
        check_val("valid_drop", 32'(bus.instr_valid), 32'd0);
    endtask

    initial begin
        int c0;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check_val("rst_req", 32'(bus.imem_req), 32'd0);
        check_val("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_val("rst_pc", bus.pc_out, RESET_PC);
        check_val("rst_instr", bus.instr_out, 32'd0);
        check_val("rst_fault", 32'(bus.fault), 32'd0);

        // Sequential fetch with zero-wait memory: one request every two cycles
        reset = 1'b0;
        sb_q.push_back(RESET_PC);
        step();
        check_val("start_valid", 32'(bus.instr_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            c0 = cyc;
            fetch_one(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
            check_val("req_period", 32'(cyc - c0), 32'd2);
        end

        // Slow memory and stalled consumer, then redirects
        fetch_one(3, 4, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0100);
        fetch_one(0, 0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
        fetch_one(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h1000_0000);
        fetch_one(1, 1, 1'b0, 16'h0, 1'b1, 26'h40, 1'b0, 32'h0);
        fetch_one(0, 2, 1'b1, 16'h0005, 1'b1, 26'h123, 1'b1, 32'h0000_0200);
        fetch_one(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
        fetch_one(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        fetch_one(2, 0, 1'b1, 16'h7FFF, 1'b1, 26'h10, 1'b0, 32'h0);
        fetch_one(0, 0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);

        // Reset in the middle of a fetch, ack arriving one cycle late
        check_val("mid_addr", bus.imem_addr, sb_q.pop_front());
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        check_val("mrst_req", 32'(bus.imem_req), 32'd0);
        check_val("mrst_addr", bus.imem_addr, RESET_PC);
        check_val("mrst_instr", bus.instr_out, 32'd0);
        step();
        idle_inputs();
        check_val("mrst_valid", 32'(bus.instr_valid), 32'd0);
        check_val("mrst_req2", 32'(bus.imem_req), 32'd1);
        check_val("mrst_addr2", bus.imem_addr, RESET_PC);
        step();
        check_val("mrst_valid2", 32'(bus.instr_valid), 32'd0);
        check_val("mrst_instr2", bus.instr_out, 32'd0);
        sb_q.push_back(RESET_PC);

        // Misaligned register target
        fetch_one(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0202);
`ifdef IFU_FAULT_EN
        check_val("mis_pc", bus.pc_out, sb_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            check_val("mis_fault", 32'(bus.fault), 32'd1);
            check_val("mis_req", 32'(bus.imem_req), 32'd0);
            check_val("mis_valid", 32'(bus.instr_valid), 32'd0);
            bus.imem_ack = 1'b1;
            bus.instr_ready = 1'b1;
            step();
            idle_inputs();
        end
        reset = 1'b1;
        step();
        check_val("clr_fault", 32'(bus.fault), 32'd0);
        reset = 1'b0;
        step();
        for (int i = 0; i < MAX_WAIT - 1; i++) step();
        check_val("to_early", 32'(bus.fault), 32'd0);
        check_val("to_req", 32'(bus.imem_req), 32'd1);
        step();
        check_val("to_fault", 32'(bus.fault), 32'd1);
        check_val("to_req_off", 32'(bus.imem_req), 32'd0);
`else
        fetch_one(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        for (int i = 0; i < MAX_WAIT + 2; i++) step();
        check_val("no_timeout_fault", 32'(bus.fault), 32'd0);
        check_val("no_timeout_req", 32'(bus.imem_req), 32'd1);
        check_val("no_timeout_addr", bus.imem_addr, sb_q.pop_front());
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
